// File: rtl/fifo_ctrl.sv
// Synchronous FIFO sequencer for a dual-port register-file memory: owns the pointers,
// occupancy count, status flags and sticky error flags; the memory itself lives outside.
module fifo_ctrl #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 3,
    parameter int RAM_DEPTH  = 8,
    parameter int AFULL_TH   = 6,
    parameter int AEMPTY_TH  = 2
) (
    input  logic                  clk,
    input  logic                  RESET_L,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    input  logic                  err_clr,
    output logic                  mem_write,
    output logic                  mem_read,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    input  logic                  mem_valid,
    input  logic                  mem_err,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  conflict
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]         DEPTH_C  = CW'(RAM_DEPTH);
    localparam logic [CW-1:0]         AFULL_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0]         AEMPTY_C = CW'(AEMPTY_TH);
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(RAM_DEPTH - 1);

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_PARTIAL = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [1:0]            state_q, state_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d, cfl_q, cfl_d;
    logic                  push_ok, pop_ok;

    // Acceptance looks only at registered state, so a full FIFO refuses a push even
    // when a pop frees a slot in the same cycle (and likewise for empty).
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    assign mem_write = push_ok;
    assign mem_read  = pop_ok;
    assign mem_waddr = wr_ptr_q;
    assign mem_raddr = rd_ptr_q;
    assign mem_wdata = data_in;
    assign data_out  = mem_dout;
    assign valid_out = mem_valid;

    assign count        = count_q;
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AFULL_C);
    assign almost_empty = (count_q <= AEMPTY_C);
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
    assign conflict     = cfl_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A new event in the clearing cycle keeps the flag set.
        ovf_d = (push & full)  | (ovf_q & ~err_clr);
        unf_d = (pop & empty)  | (unf_q & ~err_clr);
        cfl_d = mem_err        | (cfl_q & ~err_clr);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY:
                if (push_ok & ~pop_ok) state_d = ST_PARTIAL;
            ST_PARTIAL:
                if (pop_ok & ~push_ok & (count_q == CW'(1)))
                    state_d = ST_EMPTY;
                else if (push_ok & ~pop_ok & (count_q == DEPTH_C - 1'b1))
                    state_d = ST_FULL;
            ST_FULL:
                if (pop_ok) state_d = ST_PARTIAL;
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= ST_EMPTY;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            cfl_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            cfl_q    <= cfl_d;
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl with a behavioural register-file memory; read data is checked
// by a negedge monitor against a queue of expected words filled by the stimulus.
module tb_fifo_ctrl;
    localparam int DW = 6;
    localparam int AW = 3;
    localparam int D  = 8;

    logic          clk = 1'b0, RESET_L = 1'b0;
    logic          push = 1'b0, pop = 1'b0, err_clr = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          mem_write, mem_read, mem_valid, mem_err;
    logic [AW-1:0] mem_waddr, mem_raddr;
    logic [DW-1:0] mem_wdata, mem_dout, data_out;
    logic          valid_out, full, empty, almost_full, almost_empty;
    logic          overflow, underflow, conflict;
    logic [AW:0]   count;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q[$];

    fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(D), .AFULL_TH(6), .AEMPTY_TH(2)) dut (
        .clk(clk), .RESET_L(RESET_L), .push(push), .data_in(data_in), .pop(pop), .err_clr(err_clr),
        .mem_write(mem_write), .mem_read(mem_read), .mem_waddr(mem_waddr), .mem_raddr(mem_raddr),
        .mem_wdata(mem_wdata), .mem_dout(mem_dout), .mem_valid(mem_valid), .mem_err(mem_err),
        .data_out(data_out), .valid_out(valid_out), .count(count), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow), .conflict(conflict)
    );

    always #5 clk = ~clk;

    // Memory: registered read port, err on same-address read and write.
    logic [DW-1:0] ram [D];
    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            mem_valid <= 1'b0;
            mem_dout  <= '0;
            mem_err   <= 1'b0;
        end else begin
            mem_valid <= mem_read;
            if (mem_read) mem_dout <= ram[mem_raddr];
            mem_err   <= mem_write && mem_read && (mem_waddr == mem_raddr);
        end
    end
    always_ff @(posedge clk) if (RESET_L && mem_write) ram[mem_waddr] <= mem_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (RESET_L && valid_out) begin
            if (exp_q.size() == 0) chk("unexpected valid_out", 32'd1, 32'd0);
            else chk("read data", 32'(data_out), 32'(exp_q.pop_front()));
        end
    end

    task automatic cyc(input logic p, input logic q, input logic [DW-1:0] d, input logic c);
        push = p; pop = q; data_in = d; err_clr = c;
        @(posedge clk); #1;
        push = 1'b0; pop = 1'b0; err_clr = 1'b0;
    endtask

    task automatic pop_exp(input logic [DW-1:0] v);
        exp_q.push_back(v);
        cyc(1'b0, 1'b1, '0, 1'b0);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("read drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst count", count, 0);
        chk("rst empty", empty, 1);
        chk("rst aempty", almost_empty, 1);
        chk("rst full", full, 0);
        chk("rst afull", almost_full, 0);
        chk("rst mem_write", mem_write, 0);
        chk("rst mem_read", mem_read, 0);
        chk("rst flags", {overflow, underflow, conflict}, 0);
        RESET_L = 1'b1;
        @(posedge clk); #1;

        // Fill with 1..8, then refused push.
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 1'b0, DW'(i), 1'b0);
            chk("fill count", count, i);
            chk("fill afull", almost_full, (i >= 6));
            chk("fill aempty", almost_empty, (i <= 2));
            chk("fill full", full, (i == 8));
        end
        push = 1'b1; data_in = 6'd9; #1;
        chk("full mem_write", mem_write, 0);
        @(posedge clk); #1; push = 1'b0;
        chk("overflow set", overflow, 1);
        chk("overflow count", count, 8);

        // Clear coinciding with a refused push keeps the flag; plain clear drops it.
        cyc(1'b1, 1'b0, 6'd9, 1'b1);
        chk("clr+event overflow", overflow, 1);
        cyc(1'b0, 1'b0, '0, 1'b1);
        chk("clr overflow", overflow, 0);
        chk("clr count", count, 8);

        // Drain 1..8 in order, then a refused pop.
        for (int i = 1; i <= 8; i++) begin
            pop_exp(DW'(i));
            chk("drain count", count, 8 - i);
        end
        chk("drained empty", empty, 1);
        pop = 1'b1; #1;
        chk("empty mem_read", mem_read, 0);
        @(posedge clk); #1; pop = 1'b0;
        chk("underflow set", underflow, 1);
        chk("refused pop valid", valid_out, 0);
        drain();
        cyc(1'b0, 1'b0, '0, 1'b1);
        chk("clr underflow", underflow, 0);

        // Steady push&pop at count 3 with pointer wrap.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, DW'(10 + i), 1'b0);
        for (int k = 0; k < 20; k++) begin
            exp_q.push_back(DW'(10 + k));
            cyc(1'b1, 1'b1, DW'(13 + k), 1'b0);
            chk("stream count", count, 3);
        end
        for (int k = 0; k < 3; k++) pop_exp(DW'(30 + k));
        drain();
        chk("stream conflict", conflict, 0);
        chk("stream empty", empty, 1);

        // Full with push&pop: pop wins.
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, DW'(40 + i), 1'b0);
        chk("refill full", full, 1);
        exp_q.push_back(6'd40);
        cyc(1'b1, 1'b1, 6'd50, 1'b0);
        chk("full p&p overflow", overflow, 1);
        chk("full p&p count", count, 7);
        for (int i = 1; i < 8; i++) pop_exp(DW'(40 + i));
        drain();
        chk("t4 empty", empty, 1);

        // Empty with push&pop: push wins.
        push = 1'b1; pop = 1'b1; data_in = 6'd20; #1;
        chk("empty p&p mem_read", mem_read, 0);
        chk("empty p&p mem_write", mem_write, 1);
        @(posedge clk); #1; push = 1'b0; pop = 1'b0;
        chk("empty p&p underflow", underflow, 1);
        chk("empty p&p count", count, 1);
        pop_exp(6'd20);
        drain();
        cyc(1'b0, 1'b0, '0, 1'b1);
        chk("clr both", {overflow, underflow}, 0);

        // Reset with a read in flight.
        for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b0, DW'(i), 1'b0);
        chk("pre-reset count", count, 5);
        cyc(1'b0, 1'b1, '0, 1'b0);
        RESET_L = 1'b0; #1;
        chk("mid rst count", count, 0);
        chk("mid rst empty", empty, 1);
        chk("mid rst valid", valid_out, 0);
        chk("mid rst waddr", mem_waddr, 0);
        #1 RESET_L = 1'b1;
        @(posedge clk); #1;
        cyc(1'b1, 1'b0, 6'd33, 1'b0);
        pop_exp(6'd33);
        drain();
        chk("post rst empty", empty, 1);
        chk("final conflict", conflict, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
